// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file writeback queue.
// Holds default widths, the zero-register address and the entry record.
package wb_pkg;

   localparam int WB_AW    = 5;
   localparam int WB_DW    = 32;
   localparam int WB_DEPTH = 4;

   localparam logic [WB_AW-1:0] ZERO_REG = '0;

   typedef struct packed {
      logic [WB_AW-1:0] rd;
      logic [WB_DW-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_queue_if.sv
// Bundle of producer, register-file and forwarding signals of wb_queue.
// master: producer/decode side; slave: the queue itself.
interface wb_queue_if import wb_pkg::*; #(
   parameter int AW    = WB_AW,
   parameter int DW    = WB_DW,
   parameter int DEPTH = WB_DEPTH,
   localparam int CW   = $clog2(DEPTH) + 1
);

   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_rd;
   logic [DW-1:0] in_data;
   logic          wb_stall;
   logic          flush;
   logic [AW-1:0] wreg;
   logic [DW-1:0] wd;
   logic          regwrite;
   logic [AW-1:0] r1;
   logic [AW-1:0] r2;
   logic          fwd1_hit;
   logic          fwd2_hit;
   logic [DW-1:0] fwd1_data;
   logic [DW-1:0] fwd2_data;
   logic [CW-1:0] count;

   modport master (
      output in_valid, in_rd, in_data, wb_stall, flush, r1, r2,
      input  in_ready, wreg, wd, regwrite,
      input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, count
   );

   modport slave (
      input  in_valid, in_rd, in_data, wb_stall, flush, r1, r2,
      output in_ready, wreg, wd, regwrite,
      output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, count
   );

endinterface

// File: rtl/wb_fifo.sv
// In-order storage for pending writebacks: array, pointers, count.
// Ports: push/pop/flush control, head entry, all entries + valid mask, wptr.
module wb_fifo import wb_pkg::*; #(
   parameter int DEPTH = WB_DEPTH,
   parameter int AW    = WB_AW,
   parameter int DW    = WB_DW,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [AW-1:0]    push_rd,
   input  logic [DW-1:0]    push_data,
   output logic [AW-1:0]    head_rd,
   output logic [DW-1:0]    head_data,
   output logic [AW-1:0]    ent_rd [DEPTH],
   output logic [DW-1:0]    ent_data [DEPTH],
   output logic [DEPTH-1:0] ent_valid,
   output logic [PW-1:0]    wptr,
   output logic [CW-1:0]    count
);

   logic [AW-1:0] rd_q   [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [PW-1:0] wp;
   logic [PW-1:0] rp;
   logic [CW-1:0] cnt;
   logic [PW-1:0] off;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i]   <= '0;
            data_q[i] <= '0;
         end
      end else if (push && !flush) begin
         rd_q[wp]   <= push_rd;
         data_q[wp] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else if (flush) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
         cnt <= cnt + CW'(push) - CW'(pop);
      end
   end

   // Slot i is live when its distance from the read pointer is below count.
   always_comb begin
      off       = '0;
      ent_valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off          = PW'(i) - rp;
         ent_valid[i] = {1'b0, off} < cnt;
      end
   end

   assign ent_rd    = rd_q;
   assign ent_data  = data_q;
   assign head_rd   = rd_q[rp];
   assign head_data = data_q[rp];
   assign wptr      = wp;
   assign count     = cnt;

endmodule

// File: rtl/wb_queue.sv
// Writeback queue: one in-order register-file write per cycle + forwarding.
// Ports: clk, rst_n (async, active low), bus (wb_queue_if.slave).
module wb_queue import wb_pkg::*; #(
   parameter int DEPTH = WB_DEPTH,
   parameter int AW    = WB_AW,
   parameter int DW    = WB_DW
) (
   input logic       clk,
   input logic       rst_n,
   wb_queue_if.slave bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

   logic             ready;
   logic             push;
   logic             pop;
   logic [AW-1:0]    head_rd;
   logic [DW-1:0]    head_data;
   logic [AW-1:0]    ent_rd [DEPTH];
   logic [DW-1:0]    ent_data [DEPTH];
   logic [DEPTH-1:0] ent_valid;
   logic [PW-1:0]    wptr;
   logic [CW-1:0]    count;
   logic [PW-1:0]    idx;
   logic             h1;
   logic             h2;
   logic [DW-1:0]    d1;
   logic [DW-1:0]    d2;

   // Readiness looks only at stored occupancy, never at this cycle's pop.
   assign ready = (count < CW'(DEPTH)) && !bus.flush;
   // Writes to x0 finish the handshake but never occupy a slot.
   assign push  = bus.in_valid && ready && (bus.in_rd != ZR);
   assign pop   = (count != '0) && !bus.wb_stall && !bus.flush;

   wb_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .flush     (bus.flush),
      .push_rd   (bus.in_rd),
      .push_data (bus.in_data),
      .head_rd   (head_rd),
      .head_data (head_data),
      .ent_rd    (ent_rd),
      .ent_data  (ent_data),
      .ent_valid (ent_valid),
      .wptr      (wptr),
      .count     (count)
   );

   // Walk from the newest slot (wptr-1) backward; first match is youngest.
   always_comb begin
      h1  = 1'b0;
      h2  = 1'b0;
      d1  = '0;
      d2  = '0;
      idx = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = wptr - PW'(k + 1);
         if (!h1 && ent_valid[idx] && bus.r1 != ZR
             && ent_rd[idx] == bus.r1) begin
            h1 = 1'b1;
            d1 = ent_data[idx];
         end
         if (!h2 && ent_valid[idx] && bus.r2 != ZR
             && ent_rd[idx] == bus.r2) begin
            h2 = 1'b1;
            d2 = ent_data[idx];
         end
      end
   end

   assign bus.in_ready  = ready;
   assign bus.regwrite  = pop;
   assign bus.wreg      = head_rd;
   assign bus.wd        = head_data;
   assign bus.count     = count;
   assign bus.fwd1_hit  = h1;
   assign bus.fwd2_hit  = h2;
   assign bus.fwd1_data = d1;
   assign bus.fwd2_data = d2;

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: vector table, scoreboard monitor, corner sequences.
// Drives the interface directly; compares on the falling clock edge.
module tb_wb_queue;
   import wb_pkg::*;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   wb_queue_if q ();

   wb_queue dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h want %h", n, a, e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: in-order list of writes still owed to the register file.
   wb_entry_t sb[$];
   logic      m_rdy;
   logic      m_rw;
   logic      m_h;
   logic [31:0] m_d;

   function automatic void model_fwd(input logic [4:0] r, output logic h,
                                     output logic [31:0] d);
      h = 1'b0;
      d = '0;
      if (r != 0)
         for (int i = sb.size() - 1; i >= 0; i--)
            if (!h && sb[i].rd == r) begin
               h = 1'b1;
               d = sb[i].data;
            end
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
      end else begin
         m_rdy = (sb.size() < WB_DEPTH) && !q.flush;
         m_rw  = (sb.size() != 0) && !q.wb_stall && !q.flush;
         chk("sb_ready", 32'(q.in_ready), 32'(m_rdy));
         chk("sb_regwrite", 32'(q.regwrite), 32'(m_rw));
         chk("sb_count", 32'(q.count), sb.size());
         if (m_rw) begin
            chk("sb_wreg", 32'(q.wreg), 32'(sb[0].rd));
            chk("sb_wd", q.wd, sb[0].data);
         end
         model_fwd(q.r1, m_h, m_d);
         chk("sb_fwd1_hit", 32'(q.fwd1_hit), 32'(m_h));
         chk("sb_fwd1_data", q.fwd1_data, m_d);
         model_fwd(q.r2, m_h, m_d);
         chk("sb_fwd2_hit", 32'(q.fwd2_hit), 32'(m_h));
         chk("sb_fwd2_data", q.fwd2_data, m_d);
         if (q.flush) sb.delete();
         else begin
            if (m_rw) void'(sb.pop_front());
            if (q.in_valid && m_rdy && q.in_rd != 0)
               sb.push_back('{q.in_rd, q.in_data});
         end
      end
   end

   typedef struct {
      logic        v;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        stall;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic        rw;
      logic [4:0]  wreg;
      logic [31:0] wd;
      logic        h1;
      logic [31:0] d1;
      logic        h2;
      logic [31:0] d2;
      logic        rdy;
      logic [2:0]  cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t row(
      logic v, logic [4:0] rd, logic [31:0] data, logic stall,
      logic [4:0] r1, logic [4:0] r2, logic rw, logic [4:0] wreg,
      logic [31:0] wd, logic h1, logic [31:0] d1, logic h2,
      logic [31:0] d2, logic rdy, logic [2:0] cnt);
      vec_t t;
      t = '{v, rd, data, stall, r1, r2, rw, wreg, wd, h1, d1, h2, d2,
            rdy, cnt};
      return t;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      errors     = 0;
      checks     = 0;
      rst_n      = 1'b0;
      q.in_valid = 1'b0;
      q.in_rd    = '0;
      q.in_data  = '0;
      q.wb_stall = 1'b0;
      q.flush    = 1'b0;
      q.r1       = '0;
      q.r2       = '0;
      #2;
      chk("rst_regwrite", 32'(q.regwrite), 0);
      chk("rst_in_ready", 32'(q.in_ready), 1);
      chk("rst_count", 32'(q.count), 0);
      chk("rst_wreg", 32'(q.wreg), 0);
      chk("rst_wd", q.wd, 0);
      chk("rst_fwd1_hit", 32'(q.fwd1_hit), 0);
      chk("rst_fwd2_hit", 32'(q.fwd2_hit), 0);
      #10 rst_n = 1'b1;

      // single result / fill under stall / youngest forward / x0 write
      tbl.push_back(row(1,5,32'hDEADBEEF,0,5,0, 0,0,0,0,0,0,0,1,0));
      tbl.push_back(row(0,0,0,0,5,0, 1,5,32'hDEADBEEF,1,32'hDEADBEEF,0,0,1,1));
      tbl.push_back(row(0,0,0,0,5,0, 0,0,0,0,0,0,0,1,0));
      tbl.push_back(row(1,1,10,1,1,0, 0,0,0,0,0,0,0,1,0));
      tbl.push_back(row(1,2,20,1,1,0, 0,1,10,1,10,0,0,1,1));
      tbl.push_back(row(1,3,30,1,2,0, 0,1,10,1,20,0,0,1,2));
      tbl.push_back(row(1,4,40,1,3,0, 0,1,10,1,30,0,0,1,3));
      tbl.push_back(row(1,9,90,1,4,1, 0,1,10,1,40,1,10,0,4));
      tbl.push_back(row(1,9,90,0,4,1, 1,1,10,1,40,1,10,0,4));
      tbl.push_back(row(1,9,90,0,9,0, 1,2,20,0,0,0,0,1,3));
      tbl.push_back(row(0,0,0,0,9,0, 1,3,30,1,90,0,0,1,3));
      tbl.push_back(row(0,0,0,0,9,0, 1,4,40,1,90,0,0,1,2));
      tbl.push_back(row(0,0,0,0,9,0, 1,9,90,1,90,0,0,1,1));
      tbl.push_back(row(0,0,0,0,9,0, 0,2,20,0,0,0,0,1,0));
      tbl.push_back(row(1,7,1,1,7,0, 0,2,20,0,0,0,0,1,0));
      tbl.push_back(row(1,7,2,1,7,0, 0,7,1,1,1,0,0,1,1));
      tbl.push_back(row(0,0,0,1,7,0, 0,7,1,1,2,0,0,1,2));
      tbl.push_back(row(0,0,0,0,7,0, 1,7,1,1,2,0,0,1,2));
      tbl.push_back(row(0,0,0,0,7,0, 1,7,2,1,2,0,0,1,1));
      tbl.push_back(row(0,0,0,0,7,0, 0,4,40,0,0,0,0,1,0));
      tbl.push_back(row(1,0,32'hFFFFFFFF,0,0,0, 0,4,40,0,0,0,0,1,0));
      tbl.push_back(row(0,0,0,0,0,0, 0,4,40,0,0,0,0,1,0));

      foreach (tbl[i]) begin
         step();
         q.in_valid = tbl[i].v;
         q.in_rd    = tbl[i].rd;
         q.in_data  = tbl[i].data;
         q.wb_stall = tbl[i].stall;
         q.r1       = tbl[i].r1;
         q.r2       = tbl[i].r2;
         @(negedge clk);
         chk($sformatf("v%0d_regwrite", i), 32'(q.regwrite), 32'(tbl[i].rw));
         chk($sformatf("v%0d_wreg", i), 32'(q.wreg), 32'(tbl[i].wreg));
         chk($sformatf("v%0d_wd", i), q.wd, tbl[i].wd);
         chk($sformatf("v%0d_fwd1_hit", i), 32'(q.fwd1_hit), 32'(tbl[i].h1));
         chk($sformatf("v%0d_fwd1_data", i), q.fwd1_data, tbl[i].d1);
         chk($sformatf("v%0d_fwd2_hit", i), 32'(q.fwd2_hit), 32'(tbl[i].h2));
         chk($sformatf("v%0d_fwd2_data", i), q.fwd2_data, tbl[i].d2);
         chk($sformatf("v%0d_in_ready", i), 32'(q.in_ready), 32'(tbl[i].rdy));
         chk($sformatf("v%0d_count", i), 32'(q.count), 32'(tbl[i].cnt));
      end

      // flush with a full queue and a waiting producer
      step();
      q.wb_stall = 1'b1;
      q.r1       = '0;
      for (int i = 0; i < 4; i++) begin
         q.in_valid = 1'b1;
         q.in_rd    = 5'(11 + i);
         q.in_data  = 32'(100 + i);
         step();
      end
      q.in_rd   = 5'd20;
      q.in_data = 32'd200;
      @(negedge clk);
      chk("fl_full_count", 32'(q.count), 4);
      chk("fl_full_ready", 32'(q.in_ready), 0);
      step();
      q.flush    = 1'b1;
      q.wb_stall = 1'b0;
      @(negedge clk);
      chk("fl_regwrite", 32'(q.regwrite), 0);
      chk("fl_ready", 32'(q.in_ready), 0);
      step();
      q.flush = 1'b0;
      @(negedge clk);
      chk("fl_after_count", 32'(q.count), 0);
      chk("fl_after_regwrite", 32'(q.regwrite), 0);
      chk("fl_after_ready", 32'(q.in_ready), 1);
      step();
      q.in_valid = 1'b0;
      @(negedge clk);
      chk("fl_accept_count", 32'(q.count), 1);
      chk("fl_accept_regwrite", 32'(q.regwrite), 1);
      chk("fl_accept_wreg", 32'(q.wreg), 20);
      chk("fl_accept_wd", q.wd, 200);
      for (int n = 0; n < 20 && q.count != 0; n++) step();
      chk("fl_drained", 32'(q.count), 0);

      // asynchronous reset in the middle of a drain
      step();
      q.wb_stall = 1'b1;
      q.r1       = 5'd21;
      for (int i = 0; i < 3; i++) begin
         q.in_valid = 1'b1;
         q.in_rd    = 5'(21 + i);
         q.in_data  = 32'(300 + i);
         step();
      end
      q.in_valid = 1'b0;
      q.wb_stall = 1'b0;
      #2;
      chk("mr_pre_regwrite", 32'(q.regwrite), 1);
      chk("mr_pre_fwd1_hit", 32'(q.fwd1_hit), 1);
      rst_n = 1'b0;
      #1;
      chk("mr_regwrite", 32'(q.regwrite), 0);
      chk("mr_in_ready", 32'(q.in_ready), 1);
      chk("mr_count", 32'(q.count), 0);
      chk("mr_fwd1_hit", 32'(q.fwd1_hit), 0);
      chk("mr_fwd2_hit", 32'(q.fwd2_hit), 0);
      chk("mr_wreg", 32'(q.wreg), 0);
      chk("mr_wd", q.wd, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("mr_idle_regwrite", 32'(q.regwrite), 0);
      end

      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
